// File: rtl/io_posted_write_buffer_if.sv
// io_posted_write_buffer_if: request/ready word bus used on both the CPU side and the RAM-controller side.
interface io_posted_write_buffer_if #(parameter int ADDR_W = 19);
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] a;
    logic [3:0]        be;
    logic [31:0]       di;
    logic [31:0]       q;
    logic              ready;
    modport master (output rd, wr, a, be, di, input q, ready);
    modport slave (input rd, wr, a, be, di, output q, ready);
endinterface

// File: rtl/io_posted_write_buffer.sv
// io_posted_write_buffer: posts CPU RAM writes into an in-order queue drained to the RMW controller;
// reads wait until every queued write has completed.
module io_posted_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 19
) (
    input  logic                     clk,
    input  logic                     rst_b,
    io_posted_write_buffer_if.slave  io,
    io_posted_write_buffer_if.master m,
    output logic                     wb_empty,
    output logic [$clog2(DEPTH):0]   wb_level
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    typedef enum logic [2:0] {C_IDLE, C_RWAIT, C_RREQ, C_ACK, C_GAP} cstate_t;
    typedef enum logic {D_IDLE, D_BUSY} dstate_t;
    cstate_t cs;
    dstate_t ds;
    logic [ADDR_W-1:0] q_a  [DEPTH];
    logic [3:0]        q_be [DEPTH];
    logic [31:0]       q_di [DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [PW:0]       cnt;
    logic              push, pop;
    assign push     = cs == C_IDLE && io.wr && cnt < FULL;
    assign pop      = ds == D_BUSY && m.ready;
    assign wb_level = cnt;
    assign wb_empty = cnt == '0 && ds == D_IDLE;
    always_ff @(posedge clk) begin
        if (push) begin
            q_a[wp]  <= io.a;
            q_be[wp] <= io.be;
            q_di[wp] <= io.di;
        end
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cs       <= C_IDLE;
            ds       <= D_IDLE;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            io.ready <= 1'b0;
            io.q     <= '0;
            m.rd     <= 1'b0;
            m.wr     <= 1'b0;
            m.a      <= '0;
            m.be     <= '0;
            m.di     <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            case (cs)
                C_IDLE: begin
                    if (push) begin
                        io.ready <= 1'b1;
                        cs       <= C_ACK;
                    end else if (io.rd) cs <= C_RWAIT;
                end
                // reads never overtake posted writes: wait for an empty queue and an idle drain
                C_RWAIT: begin
                    if (cnt == '0 && ds == D_IDLE) begin
                        m.rd <= 1'b1;
                        m.a  <= io.a;
                        cs   <= C_RREQ;
                    end
                end
                C_RREQ: begin
                    if (m.ready) begin
                        io.q     <= m.q;
                        m.rd     <= 1'b0;
                        io.ready <= 1'b1;
                        cs       <= C_ACK;
                    end
                end
                C_ACK: begin
                    io.ready <= 1'b0;
                    cs       <= C_GAP;
                end
                default: cs <= C_IDLE;
            endcase
            case (ds)
                D_IDLE: begin
                    if (cnt != '0 && !m.rd) begin
                        m.wr <= 1'b1;
                        m.a  <= q_a[rp];
                        m.be <= q_be[rp];
                        m.di <= q_di[rp];
                        ds   <= D_BUSY;
                    end
                end
                default: begin
                    if (m.ready) begin
                        m.wr <= 1'b0;
                        rp   <= rp + 1'b1;
                        ds   <= D_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_posted_write_buffer.sv
// tb_io_posted_write_buffer: scenario tasks against a latency-programmable RAM controller model,
// with a drain-order scoreboard and a CPU-side reference image.
module tb_io_posted_write_buffer;
    logic clk;
    logic rst_b;
    logic wb_empty;
    logic [2:0] wb_level;
    int total, bad, cyc, lat, wr_done_n, last_wr_done, lvl_max;
    typedef struct packed {
        logic [18:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem     [256];

    io_posted_write_buffer_if #(.ADDR_W(19)) cpu ();
    io_posted_write_buffer_if #(.ADDR_W(19)) mb ();

    io_posted_write_buffer #(.DEPTH(4), .ADDR_W(19)) dut (
        .clk(clk), .rst_b(rst_b), .io(cpu), .m(mb), .wb_empty(wb_empty), .wb_level(wb_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // RAM controller model: answers each request with one ready pulse after lat extra cycles
    int lc;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mb.ready <= 1'b0;
            mb.q     <= '0;
            lc       <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            mb.ready <= 1'b0;
            if ((mb.rd || mb.wr) && !mb.ready) begin
                if (lc >= lat) begin
                    mb.ready <= 1'b1;
                    lc       <= 0;
                    if (mb.wr) mem[mb.a[7:0]] <= merge(mem[mb.a[7:0]], mb.be, mb.di);
                    else mb.q <= mem[mb.a[7:0]];
                end else lc <= lc + 1;
            end
        end
    end

    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        cyc++;
        total++;
        if (mb.rd && mb.wr) begin
            bad++;
            $display("FAIL overlap cyc=%0d: m_rd=%b m_wr=%b, required not both high", cyc, mb.rd, mb.wr);
        end
        if (rst_b && mb.ready && mb.wr) begin
            wr_done_n++;
            last_wr_done = cyc;
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL drain_unexpected: a=%h be=%h di=%h, required no write", mb.a, mb.be, mb.di);
            end else begin
                e = exp_wr.pop_front();
                if ({mb.a, mb.be, mb.di} !== e) begin
                    bad++;
                    $display("FAIL drain_order: got a=%h be=%h di=%h, required a=%h be=%h di=%h",
                             mb.a, mb.be, mb.di, e.a, e.be, e.d);
                end
            end
        end
        if (wb_level > lvl_max) lvl_max = wb_level;
    endtask

    task automatic cpu_write(input logic [18:0] a, input logic [3:0] be, input logic [31:0] d, output int ack);
        int n = 0;
        cpu.wr = 1'b1; cpu.a = a; cpu.be = be; cpu.di = d;
        do begin tick(); n++; end while (!cpu.ready && n < 100);
        cpu.wr = 1'b0;
        ack = cyc;
        total++;
        if (!cpu.ready) begin
            bad++;
            $display("FAIL wr_ack_timeout: a=%h io_ready=%b after %0d cycles, required 1", a, cpu.ready, n);
        end else begin
            exp_wr.push_back({a, be, d});
            ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], be, d);
        end
    endtask

    task automatic cpu_read(input logic [18:0] a, output logic [31:0] q, output int t_mrd, output int t_mrdy, output int t_rdy);
        int n = 0;
        logic [31:0] e;
        exp_rd.push_back(ref_mem[a[7:0]]);
        cpu.rd = 1'b1; cpu.a = a;
        t_mrd = -1; t_mrdy = -1;
        do begin
            tick(); n++;
            if (mb.rd && t_mrd < 0) t_mrd = cyc;
            if (mb.rd && mb.ready && t_mrdy < 0) t_mrdy = cyc;
        end while (!cpu.ready && n < 300);
        cpu.rd = 1'b0;
        t_rdy = cyc;
        q = cpu.q;
        e = exp_rd.pop_front();
        total++;
        if (!cpu.ready) begin
            bad++;
            $display("FAIL rd_timeout: a=%h io_ready=%b, required 1", a, cpu.ready);
        end else if (q !== e) begin
            bad++;
            $display("FAIL rd_data: a=%h io_q=%h, required %h", a, q, e);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!wb_empty && n < 500) begin tick(); n++; end
        total++;
        if (!wb_empty || exp_wr.size() != 0) begin
            bad++;
            $display("FAIL drain_done: wb_empty=%b pending=%0d, required 1 and 0", wb_empty, exp_wr.size());
        end
    endtask

    task automatic check_idle(input string nm);
        total++;
        if ({cpu.ready, cpu.q, mb.rd, mb.wr, mb.a, mb.be, mb.di, wb_empty, wb_level} !==
            {1'b0, 32'h0, 1'b0, 1'b0, 19'h0, 4'h0, 32'h0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL %s: io_ready=%b io_q=%h m_rd=%b m_wr=%b m_a=%h m_be=%h m_di=%h wb_empty=%b wb_level=%0d, required all zero, wb_empty=1",
                     nm, cpu.ready, cpu.q, mb.rd, mb.wr, mb.a, mb.be, mb.di, wb_empty, wb_level);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) tick();
        check_idle("reset_state");
        rst_b = 1'b1;
        repeat (2) tick();
        check_idle("after_release");
    endtask

    task automatic test_single_write();
        int c0, ack;
        lat = 0;
        c0 = cyc;
        cpu_write(19'h00010, 4'hF, 32'hDEADBEEF, ack);
        total++;
        if (ack - c0 > 2) begin
            bad++;
            $display("FAIL wr_latency: io_ready after %0d cycles, required at most 2", ack - c0);
        end
        wait_empty();
        total++;
        if (mem[8'h10] !== 32'hDEADBEEF || wb_level !== 3'd0) begin
            bad++;
            $display("FAIL single_write_ram: ram=%h level=%0d, required deadbeef and 0", mem[8'h10], wb_level);
        end
    endtask

    task automatic test_back_to_back();
        int ack[5];
        int n0, done_at4;
        lat = 10;
        lvl_max = 0;
        n0 = wr_done_n;
        for (int i = 0; i < 5; i++) begin
            cpu_write(19'h20 + 19'(i), 4'hF, $urandom, ack[i]);
            if (i == 3) done_at4 = wr_done_n - n0;
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (ack[i] - ack[i-1] !== 3) begin
                bad++;
                $display("FAIL ack_spacing %0d: %0d cycles, required 3", i, ack[i] - ack[i-1]);
            end
        end
        total++;
        if (done_at4 !== 0) begin
            bad++;
            $display("FAIL early_drain: %0d writes done before 4th ack, required 0", done_at4);
        end
        total++;
        if (wr_done_n - n0 !== 1 || last_wr_done >= ack[4]) begin
            bad++;
            $display("FAIL full_stall: done=%0d last_done=%0d ack5=%0d, required 1 done before ack5", wr_done_n - n0, last_wr_done, ack[4]);
        end
        wait_empty();
        total++;
        if (lvl_max !== 4) begin
            bad++;
            $display("FAIL level_peak: %0d, required 4", lvl_max);
        end
    endtask

    task automatic test_read_after_write();
        int ack, tm, tr, ti;
        logic [31:0] q;
        lat = 3;
        cpu_write(19'h5, 4'b0010, 32'hAABBCCDD, ack);
        cpu_read(19'h5, q, tm, tr, ti);
        total++;
        if (tm <= last_wr_done) begin
            bad++;
            $display("FAIL rd_order: m_rd at %0d, write done at %0d, required later", tm, last_wr_done);
        end
        total++;
        if (ti - tr !== 1 || q !== 32'h0000CC00) begin
            bad++;
            $display("FAIL rmw_read: io_q=%h gap=%0d, required 0000cc00 and 1", q, ti - tr);
        end
    endtask

    task automatic test_read_empty();
        int ack, c0, tm, tr, ti;
        logic [31:0] q;
        lat = 0;
        cpu_write(19'h40, 4'hF, 32'h12345678, ack);
        wait_empty();
        repeat (2) tick();
        lat = 2;
        c0 = cyc;
        cpu_read(19'h40, q, tm, tr, ti);
        total++;
        if (tm - c0 !== 2 || tr - tm !== 3 || ti - tr !== 1) begin
            bad++;
            $display("FAIL rd_latency: m_rd=+%0d m_ready=+%0d io_ready=+%0d, required +2 +5 +6", tm - c0, tr - c0, ti - c0);
        end
        repeat (3) tick();
        total++;
        if (cpu.q !== 32'h12345678) begin
            bad++;
            $display("FAIL io_q_hold: %h, required 12345678", cpu.q);
        end
    endtask

    task automatic test_random_mix();
        int ack, tm, tr, ti;
        logic [31:0] q;
        logic [18:0] a;
        for (int i = 0; i < 1500; i++) begin
            lat = $urandom_range(0, 4);
            a = 19'h80 + 19'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 6) cpu_write(a, 4'($urandom), $urandom, ack);
            else cpu_read(a, q, tm, tr, ti);
        end
        wait_empty();
        tick();
        for (int i = 0; i < 256; i++) begin
            total++;
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                $display("FAIL final_image[%0d]: ram=%h, required %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int ack, seen;
        lat = 20;
        for (int i = 0; i < 3; i++) cpu_write(19'h60 + 19'(i), 4'hF, $urandom, ack);
        total++;
        if (mb.wr !== 1'b1 || wb_level < 3'd2) begin
            bad++;
            $display("FAIL pre_reset: m_wr=%b level=%0d, required 1 and >=2", mb.wr, wb_level);
        end
        rst_b = 1'b0;
        #1;
        check_idle("async_reset");
        exp_wr.delete();
        repeat (2) tick();
        rst_b = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mb.wr) seen++;
        end
        total++;
        if (seen !== 0 || wb_level !== 3'd0 || wb_empty !== 1'b1) begin
            bad++;
            $display("FAIL post_reset: m_wr cycles=%0d level=%0d empty=%b, required 0 0 1", seen, wb_level, wb_empty);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; lat = 0; wr_done_n = 0; last_wr_done = 0; lvl_max = 0;
        rst_b = 1'b0;
        cpu.rd = 1'b0; cpu.wr = 1'b0; cpu.a = '0; cpu.be = '0; cpu.di = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_after_write();
        test_read_empty();
        test_random_mix();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
